// File: rtl/axi_io_pmp_enforcer_if.sv
// rtl/axi_io_pmp_enforcer_if.sv - AXI4 bundle without user signals, master/slave modports
interface axi_io_pmp_enforcer_if #(
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64,
    parameter int ID_WIDTH   = 8
);
    logic [ID_WIDTH-1:0]     awid;
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic [7:0]              awlen;
    logic [2:0]              awsize;
    logic [1:0]              awburst;
    logic                    awlock;
    logic [3:0]              awcache;
    logic [2:0]              awprot;
    logic [3:0]              awqos;
    logic [3:0]              awregion;
    logic                    awvalid;
    logic                    awready;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wlast;
    logic                    wvalid;
    logic                    wready;
    logic [ID_WIDTH-1:0]     bid;
    logic [1:0]              bresp;
    logic                    bvalid;
    logic                    bready;
    logic [ID_WIDTH-1:0]     arid;
    logic [ADDR_WIDTH-1:0]   araddr;
    logic [7:0]              arlen;
    logic [2:0]              arsize;
    logic [1:0]              arburst;
    logic                    arlock;
    logic [3:0]              arcache;
    logic [2:0]              arprot;
    logic [3:0]              arqos;
    logic [3:0]              arregion;
    logic                    arvalid;
    logic                    arready;
    logic [ID_WIDTH-1:0]     rid;
    logic [DATA_WIDTH-1:0]   rdata;
    logic [1:0]              rresp;
    logic                    rlast;
    logic                    rvalid;
    logic                    rready;

    modport master (
        output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awregion, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready,
        output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arregion, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready
    );

    modport slave (
        input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awregion, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready,
        input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arregion, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready
    );
endinterface

// File: rtl/axi_io_pmp_enforcer.sv
// rtl/axi_io_pmp_enforcer.sv - AXI4 IO-PMP: checks AW/AR, forwards allowed, terminates denied with SLVERR
module axi_io_pmp_enforcer #(
    parameter int DATA_WIDTH    = 64,
    parameter int ADDR_WIDTH    = 64,
    parameter int ID_WIDTH      = 8,
    parameter int PLEN          = 56,
    parameter int PMP_LEN       = 54,
    parameter int NR_ENTRIES    = 16,
    parameter int ERR_CNT_WIDTH = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    axi_io_pmp_enforcer_if.slave          s_axi,
    axi_io_pmp_enforcer_if.master         m_axi,
    input  logic                          cfg_we,
    input  logic [3:0]                    cfg_idx,
    input  logic [PMP_LEN-1:0]            cfg_addr_wdata,
    input  logic [7:0]                    cfg_wdata,
    output logic [NR_ENTRIES*PMP_LEN-1:0] cfg_addr_o,
    output logic [NR_ENTRIES*8-1:0]       cfg_o,
    output logic [ERR_CNT_WIDTH-1:0]      err_cnt_o,
    output logic                          err_irq_o,
    output logic [ADDR_WIDTH-1:0]         err_addr_o
);
    typedef enum logic [1:0] {W_IDLE, W_DRAIN, W_RESP} w_state_e;
    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_GEN}   r_state_e;

    logic [7:0]               cfg_q  [NR_ENTRIES];
    logic [PMP_LEN-1:0]       addr_q [NR_ENTRIES];
    w_state_e                 w_state_q, w_state_d;
    r_state_e                 r_state_q, r_state_d;
    logic [7:0]               wr_out_q;
    logic                     rd_busy_q;
    logic [ID_WIDTH-1:0]      bid_q, rid_q;
    logic [8:0]               rcnt_q, rcnt_d;
    logic [ERR_CNT_WIDTH-1:0] err_cnt_q;
    logic                     err_irq_q;
    logic [ADDR_WIDTH-1:0]    err_addr_q;
    logic [PLEN-1:0]          aw_end, ar_end;
    logic                     aw_ok, ar_ok, wr_pass;
    logic                     aw_deny_hs, ar_deny_hs;
    logic [ERR_CNT_WIDTH:0]   err_sum;

    // Lowest-numbered matching entry decides (S-mode view); no match denies.
    function automatic logic pmp_ok(input logic [PLEN-1:0] a, input logic wr);
        logic [PMP_LEN-1:0] wa, prev, care;
        logic               hit, done, ok;
        wa   = PMP_LEN'(a >> 2);
        prev = '0;
        done = 1'b0;
        ok   = 1'b0;
        for (int i = 0; i < NR_ENTRIES; i++) begin
            care = ~(addr_q[i] ^ (addr_q[i] + PMP_LEN'(1)));
            case (cfg_q[i][4:3])
                2'd1:    hit = (wa >= prev) && (wa < addr_q[i]);
                2'd2:    hit = (wa == addr_q[i]);
                2'd3:    hit = ((wa & care) == (addr_q[i] & care));
                default: hit = 1'b0;
            endcase
            if (hit && !done) begin
                done = 1'b1;
                ok   = wr ? cfg_q[i][1] : cfg_q[i][0];
            end
            prev = addr_q[i];
        end
        return ok;
    endfunction

    // Entry writes land at the next edge; a locked entry only clears on reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NR_ENTRIES; i++) begin
                cfg_q[i]  <= '0;
                addr_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NR_ENTRIES; i++) begin
                if (cfg_we && (cfg_idx == 4'(i)) && !cfg_q[i][7]) begin
                    cfg_q[i]  <= cfg_wdata;
                    addr_q[i] <= cfg_addr_wdata;
                end
            end
        end
    end

    // Flatten the entry arrays onto the observation ports.
    always_comb begin
        cfg_o      = '0;
        cfg_addr_o = '0;
        for (int i = 0; i < NR_ENTRIES; i++) begin
            cfg_o[i*8 +: 8]                = cfg_q[i];
            cfg_addr_o[i*PMP_LEN +: PMP_LEN] = addr_q[i];
        end
    end

    // Start and last byte of each request; only INCR bursts extend past the start.
    always_comb begin
        aw_end = s_axi.awaddr[PLEN-1:0];
        ar_end = s_axi.araddr[PLEN-1:0];
        if (s_axi.awburst == 2'b01)
            aw_end = s_axi.awaddr[PLEN-1:0] + (PLEN'({1'b0, s_axi.awlen} + 9'd1) << s_axi.awsize) - PLEN'(1);
        if (s_axi.arburst == 2'b01)
            ar_end = s_axi.araddr[PLEN-1:0] + (PLEN'({1'b0, s_axi.arlen} + 9'd1) << s_axi.arsize) - PLEN'(1);
        aw_ok = pmp_ok(s_axi.awaddr[PLEN-1:0], 1'b1) && pmp_ok(aw_end, 1'b1);
        ar_ok = pmp_ok(s_axi.araddr[PLEN-1:0], 1'b0) && pmp_ok(ar_end, 1'b0);
    end

    assign m_axi.awid     = s_axi.awid;
    assign m_axi.awaddr   = s_axi.awaddr;
    assign m_axi.awlen    = s_axi.awlen;
    assign m_axi.awsize   = s_axi.awsize;
    assign m_axi.awburst  = s_axi.awburst;
    assign m_axi.awlock   = s_axi.awlock;
    assign m_axi.awcache  = s_axi.awcache;
    assign m_axi.awprot   = s_axi.awprot;
    assign m_axi.awqos    = s_axi.awqos;
    assign m_axi.awregion = s_axi.awregion;
    assign m_axi.wdata    = s_axi.wdata;
    assign m_axi.wstrb    = s_axi.wstrb;
    assign m_axi.wlast    = s_axi.wlast;
    assign m_axi.arid     = s_axi.arid;
    assign m_axi.araddr   = s_axi.araddr;
    assign m_axi.arlen    = s_axi.arlen;
    assign m_axi.arsize   = s_axi.arsize;
    assign m_axi.arburst  = s_axi.arburst;
    assign m_axi.arlock   = s_axi.arlock;
    assign m_axi.arcache  = s_axi.arcache;
    assign m_axi.arprot   = s_axi.arprot;
    assign m_axi.arqos    = s_axi.arqos;
    assign m_axi.arregion = s_axi.arregion;
    assign wr_pass        = (wr_out_q != 8'd0);

    // Write-side state, outstanding-allowed-burst count and latched denied ID.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            w_state_q <= W_IDLE;
            wr_out_q  <= '0;
            bid_q     <= '0;
        end else begin
            w_state_q <= w_state_d;
            wr_out_q  <= wr_out_q + 8'(m_axi.awvalid && m_axi.awready)
                                  - 8'(m_axi.wvalid && m_axi.wready && s_axi.wlast);
            if (aw_deny_hs) bid_q <= s_axi.awid;
        end
    end

    // Write path: pass-through when allowed, otherwise wait for W order, drain, answer SLVERR.
    always_comb begin
        w_state_d     = w_state_q;
        aw_deny_hs    = 1'b0;
        m_axi.awvalid = 1'b0;
        s_axi.awready = 1'b0;
        m_axi.wvalid  = s_axi.wvalid && wr_pass;
        s_axi.wready  = m_axi.wready && wr_pass;
        s_axi.bvalid  = m_axi.bvalid;
        s_axi.bid     = m_axi.bid;
        s_axi.bresp   = m_axi.bresp;
        m_axi.bready  = s_axi.bready;
        case (w_state_q)
            W_IDLE: begin
                if (s_axi.awvalid) begin
                    if (aw_ok) begin
                        m_axi.awvalid = 1'b1;
                        s_axi.awready = m_axi.awready;
                    end else if (wr_out_q == 8'd0) begin
                        s_axi.awready = 1'b1;
                        aw_deny_hs    = 1'b1;
                        w_state_d     = W_DRAIN;
                    end
                end
            end
            W_DRAIN: begin
                m_axi.wvalid = 1'b0;
                s_axi.wready = 1'b1;
                if (s_axi.wvalid && s_axi.wlast) w_state_d = W_RESP;
            end
            W_RESP: begin
                s_axi.bvalid = 1'b1;
                s_axi.bid    = bid_q;
                s_axi.bresp  = 2'b10;
                m_axi.bready = 1'b0;
                if (s_axi.bready) w_state_d = W_IDLE;
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    // Read-side state, local beat counter, downstream burst tracking.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state_q <= R_IDLE;
            rcnt_q    <= '0;
            rid_q     <= '0;
            rd_busy_q <= 1'b0;
        end else begin
            r_state_q <= r_state_d;
            rcnt_q    <= rcnt_d;
            if (ar_deny_hs) rid_q <= s_axi.arid;
            if (m_axi.rvalid && m_axi.rready) rd_busy_q <= !m_axi.rlast;
        end
    end

    // Read path: a denied AR waits for any downstream burst to finish so bursts never interleave.
    always_comb begin
        r_state_d     = r_state_q;
        rcnt_d        = rcnt_q;
        ar_deny_hs    = 1'b0;
        m_axi.arvalid = 1'b0;
        s_axi.arready = 1'b0;
        s_axi.rvalid  = m_axi.rvalid;
        s_axi.rid     = m_axi.rid;
        s_axi.rdata   = m_axi.rdata;
        s_axi.rresp   = m_axi.rresp;
        s_axi.rlast   = m_axi.rlast;
        m_axi.rready  = s_axi.rready;
        case (r_state_q)
            R_IDLE: begin
                if (s_axi.arvalid) begin
                    if (ar_ok) begin
                        m_axi.arvalid = 1'b1;
                        s_axi.arready = m_axi.arready;
                    end else begin
                        s_axi.arready = 1'b1;
                        ar_deny_hs    = 1'b1;
                        rcnt_d        = {1'b0, s_axi.arlen} + 9'd1;
                        r_state_d     = R_WAIT;
                    end
                end
            end
            R_WAIT: begin
                if (!rd_busy_q) begin
                    s_axi.rvalid = 1'b0;
                    m_axi.rready = 1'b0;
                    r_state_d    = R_GEN;
                end
            end
            R_GEN: begin
                m_axi.rready = 1'b0;
                s_axi.rvalid = 1'b1;
                s_axi.rid    = rid_q;
                s_axi.rdata  = {DATA_WIDTH{1'b0}};
                s_axi.rresp  = 2'b10;
                s_axi.rlast  = (rcnt_q == 9'd1);
                if (s_axi.rready) begin
                    rcnt_d = rcnt_q - 9'd1;
                    if (rcnt_q == 9'd1) r_state_d = R_IDLE;
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    assign err_sum = {1'b0, err_cnt_q} + (ERR_CNT_WIDTH+1)'(aw_deny_hs) + (ERR_CNT_WIDTH+1)'(ar_deny_hs);

    // Violation reporting: saturating count, one irq pulse per cycle with denials, AW address wins.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_cnt_q  <= '0;
            err_irq_q  <= 1'b0;
            err_addr_q <= '0;
        end else begin
            err_irq_q <= aw_deny_hs || ar_deny_hs;
            if (aw_deny_hs || ar_deny_hs) begin
                err_cnt_q  <= err_sum[ERR_CNT_WIDTH] ? '1 : err_sum[ERR_CNT_WIDTH-1:0];
                err_addr_q <= aw_deny_hs ? s_axi.awaddr : s_axi.araddr;
            end
        end
    end

    assign err_cnt_o  = err_cnt_q;
    assign err_irq_o  = err_irq_q;
    assign err_addr_o = err_addr_q;
endmodule

// File: tb/tb_axi_io_pmp_enforcer.sv
// tb/tb_axi_io_pmp_enforcer.sv - scoreboard bench for axi_io_pmp_enforcer
module tb_axi_io_pmp_enforcer;
    localparam int NR = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              cfg_we = 1'b0;
    logic [3:0]        cfg_idx = '0;
    logic [53:0]       cfg_addr_wdata = '0;
    logic [7:0]        cfg_wdata = '0;
    logic [NR*54-1:0]  cfg_addr_o;
    logic [NR*8-1:0]   cfg_o;
    logic [15:0]       err_cnt_o;
    logic              err_irq_o;
    logic [63:0]       err_addr_o;

    axi_io_pmp_enforcer_if #(.ADDR_WIDTH(64), .DATA_WIDTH(64), .ID_WIDTH(8)) s_if ();
    axi_io_pmp_enforcer_if #(.ADDR_WIDTH(64), .DATA_WIDTH(64), .ID_WIDTH(8)) m_if ();

    axi_io_pmp_enforcer #(.NR_ENTRIES(NR)) dut (
        .clk(clk), .rst(rst), .s_axi(s_if.slave), .m_axi(m_if.master),
        .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_addr_wdata(cfg_addr_wdata), .cfg_wdata(cfg_wdata),
        .cfg_addr_o(cfg_addr_o), .cfg_o(cfg_o), .err_cnt_o(err_cnt_o), .err_irq_o(err_irq_o),
        .err_addr_o(err_addr_o)
    );

    always #5 clk = ~clk;

    typedef struct { logic [7:0] id; logic [63:0] data; logic [1:0] resp; logic last; } r_exp_t;
    typedef struct { logic [7:0] id; logic [1:0] resp; } b_exp_t;
    typedef struct { logic [7:0] id; logic [63:0] addr; logic [7:0] len; } req_t;

    r_exp_t exp_r[$];
    b_exp_t exp_b[$];
    req_t   exp_mar[$], exp_maw[$];
    int n_vec = 0, n_err = 0, m_w_cnt = 0, irq_cnt = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: pops and compares whenever a handshake is about to complete.
    initial begin : monitor
        r_exp_t er; b_exp_t eb; req_t eq;
        forever begin
            @(negedge clk);
            if (s_if.rvalid && s_if.rready) begin
                if (exp_r.size() == 0) check("r_unexpected", {56'd0, s_if.rid}, 64'hFFFF);
                else begin
                    er = exp_r.pop_front();
                    check("r_data", s_if.rdata, er.data);
                    check("r_id_resp_last", {53'd0, s_if.rid, s_if.rresp, s_if.rlast}, {53'd0, er.id, er.resp, er.last});
                end
            end
            if (s_if.bvalid && s_if.bready) begin
                if (exp_b.size() == 0) check("b_unexpected", {56'd0, s_if.bid}, 64'hFFFF);
                else begin
                    eb = exp_b.pop_front();
                    check("b_id_resp", {54'd0, s_if.bid, s_if.bresp}, {54'd0, eb.id, eb.resp});
                end
            end
            if (m_if.arvalid && m_if.arready) begin
                if (exp_mar.size() == 0) check("m_ar_unexpected", m_if.araddr, 64'hFFFF_FFFF_FFFF_FFFF);
                else begin
                    eq = exp_mar.pop_front();
                    check("m_ar_addr", m_if.araddr, eq.addr);
                    check("m_ar_id_len", {48'd0, m_if.arid, m_if.arlen}, {48'd0, eq.id, eq.len});
                end
            end
            if (m_if.awvalid && m_if.awready) begin
                if (exp_maw.size() == 0) check("m_aw_unexpected", m_if.awaddr, 64'hFFFF_FFFF_FFFF_FFFF);
                else begin
                    eq = exp_maw.pop_front();
                    check("m_aw_addr", m_if.awaddr, eq.addr);
                    check("m_aw_id_len", {48'd0, m_if.awid, m_if.awlen}, {48'd0, eq.id, eq.len});
                end
            end
            if (m_if.wvalid && m_if.wready) m_w_cnt++;
            if (err_irq_o) irq_cnt++;
        end
    end

    // Downstream memory: always ready, read data = address + beat index, OKAY responses.
    req_t       mem_rq[$];
    logic [7:0] mem_awq[$], mem_bq[$];
    int         mem_beat = 0;
    initial begin : memory
        logic ar_hs, aw_hs, wl_hs, r_hs, b_hs;
        req_t rq;
        logic [7:0] awid;
        m_if.awready = 1'b1; m_if.wready = 1'b1; m_if.arready = 1'b1;
        m_if.bvalid = 1'b0; m_if.bid = '0; m_if.bresp = '0;
        m_if.rvalid = 1'b0; m_if.rid = '0; m_if.rdata = '0; m_if.rresp = '0; m_if.rlast = 1'b0;
        forever begin
            @(negedge clk);
            ar_hs = m_if.arvalid && m_if.arready;
            rq    = '{m_if.arid, m_if.araddr, m_if.arlen};
            aw_hs = m_if.awvalid && m_if.awready;
            awid  = m_if.awid;
            wl_hs = m_if.wvalid && m_if.wready && m_if.wlast;
            r_hs  = m_if.rvalid && m_if.rready;
            b_hs  = m_if.bvalid && m_if.bready;
            @(posedge clk); #1;
            if (ar_hs) mem_rq.push_back(rq);
            if (aw_hs) mem_awq.push_back(awid);
            if (r_hs) begin
                if (mem_beat == int'(mem_rq[0].len)) begin
                    void'(mem_rq.pop_front());
                    mem_beat = 0;
                end else mem_beat++;
            end
            if (b_hs) void'(mem_bq.pop_front());
            if (wl_hs && mem_awq.size() > 0) mem_bq.push_back(mem_awq.pop_front());
            m_if.rvalid = (mem_rq.size() > 0);
            if (mem_rq.size() > 0) begin
                m_if.rid   = mem_rq[0].id;
                m_if.rdata = mem_rq[0].addr + 64'(mem_beat);
                m_if.rlast = (mem_beat == int'(mem_rq[0].len));
            end
            m_if.bvalid = (mem_bq.size() > 0);
            if (mem_bq.size() > 0) m_if.bid = mem_bq[0];
        end
    end

    task automatic cfg_write(input logic [3:0] idx, input logic [53:0] a, input logic [7:0] c);
        cfg_we = 1'b1; cfg_idx = idx; cfg_addr_wdata = a; cfg_wdata = c;
        @(posedge clk); #1;
        cfg_we = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic send_ar(input logic [7:0] id, input logic [63:0] addr, input logic [7:0] len);
        s_if.arid = id; s_if.araddr = addr; s_if.arlen = len; s_if.arsize = 3'd3; s_if.arburst = 2'b01;
        s_if.arvalid = 1'b1;
        for (int t = 0; t < 300; t++) begin
            @(negedge clk);
            if (s_if.arready) break;
            if (t == 299) check("ar_timeout", 64'd0, 64'd1);
        end
        @(posedge clk); #1;
        s_if.arvalid = 1'b0;
    endtask

    task automatic send_aw(input logic [7:0] id, input logic [63:0] addr, input logic [7:0] len);
        s_if.awid = id; s_if.awaddr = addr; s_if.awlen = len; s_if.awsize = 3'd3; s_if.awburst = 2'b01;
        s_if.awvalid = 1'b1;
        for (int t = 0; t < 300; t++) begin
            @(negedge clk);
            if (s_if.awready) break;
            if (t == 299) check("aw_timeout", 64'd0, 64'd1);
        end
        @(posedge clk); #1;
        s_if.awvalid = 1'b0;
    endtask

    task automatic send_w(input int n);
        for (int i = 0; i < n; i++) begin
            s_if.wdata = 64'(i) + 64'h100; s_if.wlast = (i == n - 1); s_if.wvalid = 1'b1;
            for (int t = 0; t < 300; t++) begin
                @(negedge clk);
                if (s_if.wready) break;
                if (t == 299) check("w_timeout", 64'd0, 64'd1);
            end
            @(posedge clk); #1;
        end
        s_if.wvalid = 1'b0; s_if.wlast = 1'b0;
    endtask

    task automatic wait_drain();
        for (int t = 0; t < 400; t++) begin
            if (exp_r.size() == 0 && exp_b.size() == 0 && exp_mar.size() == 0 && exp_maw.size() == 0) break;
            @(posedge clk); #1;
            if (t == 399) check("drain_timeout", 64'(exp_r.size() + exp_b.size()), 64'd0);
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin : stimulus
        s_if.awvalid = 0; s_if.awid = 0; s_if.awaddr = 0; s_if.awlen = 0; s_if.awsize = 0; s_if.awburst = 0;
        s_if.awlock = 0; s_if.awcache = 0; s_if.awprot = 0; s_if.awqos = 0; s_if.awregion = 0;
        s_if.wvalid = 0; s_if.wdata = 0; s_if.wstrb = '1; s_if.wlast = 0; s_if.bready = 1;
        s_if.arvalid = 0; s_if.arid = 0; s_if.araddr = 0; s_if.arlen = 0; s_if.arsize = 0; s_if.arburst = 0;
        s_if.arlock = 0; s_if.arcache = 0; s_if.arprot = 0; s_if.arqos = 0; s_if.arregion = 0;
        s_if.rready = 1;

        repeat (2) @(negedge clk);
        check("rst_err_cnt", 64'(err_cnt_o), 64'd0);
        check("rst_err_irq", 64'(err_irq_o), 64'd0);
        check("rst_err_addr", err_addr_o, 64'd0);
        check("rst_cfg", 64'(cfg_o), 64'd0);
        check("rst_valids", {58'd0, s_if.rvalid, s_if.bvalid, s_if.awready, s_if.arready, m_if.arvalid, m_if.awvalid}, 64'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;

        // NAPOT 0x8000_0000 / 64KiB, R|W
        cfg_write(4'd0, 54'h2000_1FFF, 8'h1B);
        check("cfg0", 64'(cfg_o[7:0]), 64'h1B);
        check("cfg0_addr", 64'(cfg_addr_o[53:0]), 64'h2000_1FFF);

        // Allowed AR forwarded, 4 downstream beats
        exp_mar.push_back('{8'h11, 64'h8000_1000, 8'd3});
        for (int i = 0; i < 4; i++) exp_r.push_back('{8'h11, 64'h8000_1000 + 64'(i), 2'b00, (i == 3)});
        send_ar(8'h11, 64'h8000_1000, 8'd3);
        wait_drain();

        // Denied AR: 8 local SLVERR beats
        for (int i = 0; i < 8; i++) exp_r.push_back('{8'h5A, 64'd0, 2'b10, (i == 7)});
        send_ar(8'h5A, 64'h9000_0000, 8'd7);
        wait_drain();
        check("ar_deny_cnt", 64'(err_cnt_o), 64'd1);
        check("ar_deny_addr", err_addr_o, 64'h9000_0000);
        check("ar_deny_irq", 64'(irq_cnt), 64'd1);

        // R-only entry: write denied, W absorbed
        cfg_write(4'd0, 54'h2000_1FFF, 8'h19);
        exp_b.push_back('{8'd3, 2'b10});
        send_aw(8'd3, 64'h8000_0000, 8'd1);
        send_w(2);
        wait_drain();
        check("aw_deny_cnt", 64'(err_cnt_o), 64'd2);
        check("aw_deny_mw", 64'(m_w_cnt), 64'd0);

        // Burst end crosses the region: denied; an inside burst is allowed
        cfg_write(4'd0, 54'h2000_1FFF, 8'h1B);
        exp_b.push_back('{8'd4, 2'b10});
        send_aw(8'd4, 64'h8000_FFF8, 8'd1);
        send_w(2);
        wait_drain();
        check("cross_cnt", 64'(err_cnt_o), 64'd3);
        check("cross_addr", err_addr_o, 64'h8000_FFF8);
        exp_maw.push_back('{8'd6, 64'h8000_0100, 8'd1});
        exp_b.push_back('{8'd6, 2'b00});
        send_aw(8'd6, 64'h8000_0100, 8'd1);
        send_w(2);
        wait_drain();
        check("allow_mw", 64'(m_w_cnt), 64'd2);

        // Denied AW held behind an in-flight allowed burst
        exp_maw.push_back('{8'd7, 64'h8000_0200, 8'd1});
        exp_b.push_back('{8'd7, 2'b00});
        exp_b.push_back('{8'd8, 2'b10});
        send_aw(8'd7, 64'h8000_0200, 8'd1);
        fork
            send_aw(8'd8, 64'h9000_0040, 8'd0);
            begin
                repeat (3) @(negedge clk);
                check("aw_held", 64'(s_if.awready), 64'd0);
                @(posedge clk); #1;
                send_w(2);
                send_w(1);
            end
        join
        wait_drain();
        check("held_cnt", 64'(err_cnt_o), 64'd4);
        check("held_mw", 64'(m_w_cnt), 64'd4);

        // Lock entry 0, then try to clear it; out-of-range index ignored
        cfg_write(4'd0, 54'h2000_1FFF, 8'h9B);
        cfg_write(4'd0, 54'h0, 8'h00);
        check("lock_cfg", 64'(cfg_o[7:0]), 64'h9B);
        check("lock_addr", 64'(cfg_addr_o[53:0]), 64'h2000_1FFF);
        cfg_write(4'd9, 54'h1234, 8'h1B);
        check("idx_oob", 64'(cfg_o), 64'h9B);

        // Simultaneous AW and AR denials
        exp_b.push_back('{8'd9, 2'b10});
        exp_r.push_back('{8'h21, 64'd0, 2'b10, 1'b1});
        fork
            begin send_aw(8'd9, 64'hA000_0000, 8'd0); send_w(1); end
            send_ar(8'h21, 64'hB000_0000, 8'd0);
        join
        wait_drain();
        check("dual_cnt", 64'(err_cnt_o), 64'd6);
        check("dual_addr", err_addr_o, 64'hA000_0000);
        check("dual_irq", 64'(irq_cnt), 64'd5);

        // Reset in the middle of a local read burst
        s_if.rready = 1'b0;
        send_ar(8'h33, 64'h9000_0000, 8'd7);
        repeat (3) @(negedge clk);
        check("gen_rvalid", 64'(s_if.rvalid), 64'd1);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("abort_rvalid", 64'(s_if.rvalid), 64'd0);
        check("abort_cfg", 64'(cfg_o), 64'd0);
        check("abort_cnt", 64'(err_cnt_o), 64'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        s_if.rready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("abort_no_r", 64'(s_if.rvalid), 64'd0);
        check("left_r", 64'(exp_r.size()), 64'd0);
        check("left_b", 64'(exp_b.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
